// File: rtl/fb_arbiter.sv
// fb_arbiter: one-access-per-cycle arbiter for the 128x160 RGB565 framebuffer.
// Display reads have priority; a starvation counter guarantees writer progress.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   disp_req/addr/gnt       display read request, address, grant
//   disp_rvalid/rdata       registered read data, valid the cycle after grant
//   draw_req/addr/data/gnt  drawing-engine write request and grant
//   fill_start/color        start a clear-to-colour of the whole buffer
//   fill_busy/done          fill in progress / one-cycle completion pulse
//   err_oob                 sticky out-of-range access flag
//   mem_we/addr/din/dout    single-port pixel memory (sync write, comb read)
//
// Build option: define FB_BOUNDS_CHECK_EN to block out-of-range accesses and
// report them on err_oob; otherwise addresses pass through and err_oob is 0.

module fb_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int NUM_PIXELS = 20480,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              draw_req,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_data,
    output logic              draw_gnt,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_color,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              err_oob,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] fill_cnt;
    logic [DATA_W-1:0] fill_col;
    logic [SW-1:0]     starve_cnt;

    logic wr_req;
    logic starved;
    logic wr_win;
    logic disp_win;
    logic fill_gnt;
    logic last_px;
    logic draw_oob;
    logic disp_oob;

`ifdef FB_BOUNDS_CHECK_EN
    assign draw_oob = draw_addr >= ADDR_W'(NUM_PIXELS);
    assign disp_oob = disp_addr >= ADDR_W'(NUM_PIXELS);
`else
    assign draw_oob = 1'b0;
    assign disp_oob = 1'b0;
`endif

    always_comb begin
        // In FILL the fill engine is the writer and always requests.
        wr_req   = (state == FILL) || draw_req;
        starved  = (starve_cnt == SW'(STARVE_MAX));
        wr_win   = rst_n && wr_req && (!disp_req || starved);
        disp_win = rst_n && disp_req && !wr_win;
        fill_gnt = wr_win && (state == FILL);
        draw_gnt = wr_win && (state == IDLE);
        disp_gnt = disp_win;
        last_px  = (fill_cnt == ADDR_W'(NUM_PIXELS - 1));

        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        unique case (1'b1)
            disp_win: begin
                mem_addr = disp_addr;
            end
            fill_gnt: begin
                mem_addr = fill_cnt;
                mem_din  = fill_col;
                mem_we   = 1'b1;
            end
            draw_gnt: begin
                mem_addr = draw_addr;
                mem_din  = draw_data;
                mem_we   = !draw_oob;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            fill_cnt    <= '0;
            fill_col    <= '0;
            starve_cnt  <= '0;
            disp_rvalid <= 1'b0;
            disp_rdata  <= '0;
            fill_busy   <= 1'b0;
            fill_done   <= 1'b0;
        end else begin
            disp_rvalid <= disp_win;
            if (disp_win) begin
                disp_rdata <= disp_oob ? '0 : mem_dout;
            end
            fill_done <= 1'b0;

            // A requesting writer that loses can only have lost to display.
            if (!wr_req || wr_win) begin
                starve_cnt <= '0;
            end else if (!starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (state == IDLE) begin
                if (fill_start && !fill_busy) begin
                    state      <= FILL;
                    fill_col   <= fill_color;
                    fill_cnt   <= '0;
                    fill_busy  <= 1'b1;
                    starve_cnt <= '0;
                end
            end else if (fill_gnt) begin
                fill_cnt <= fill_cnt + 1'b1;
                if (last_px) begin
                    state      <= IDLE;
                    fill_busy  <= 1'b0;
                    fill_done  <= 1'b1;
                    starve_cnt <= '0;
                end
            end
        end
    end

`ifdef FB_BOUNDS_CHECK_EN
    logic oob_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oob_q <= 1'b0;
        end else if ((draw_gnt && draw_oob) || (disp_win && disp_oob)) begin
            oob_q <= 1'b1;
        end
    end

    assign err_oob = oob_q;
`else
    assign err_oob = 1'b0;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: randomized scoreboard bench for fb_arbiter with a
// behavioural pixel memory and a rule-level reference model.

module tb_fb_arbiter;

    localparam int AW = 15;
    localparam int DW = 16;
    localparam int NP = 20480;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_gnt;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          draw_req;
    logic [AW-1:0] draw_addr;
    logic [DW-1:0] draw_data;
    logic          draw_gnt;
    logic          fill_start;
    logic [DW-1:0] fill_color;
    logic          fill_busy;
    logic          fill_done;
    logic          err_oob;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    always #5 clk = ~clk;

    fb_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .draw_req(draw_req), .draw_addr(draw_addr), .draw_data(draw_data),
        .draw_gnt(draw_gnt),
        .fill_start(fill_start), .fill_color(fill_color),
        .fill_busy(fill_busy), .fill_done(fill_done), .err_oob(err_oob),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    // Pixel memory driven only through the DUT's mem_* port.
    logic [DW-1:0] mem [NP];
    assign mem_dout = (int'(mem_addr) < NP) ? mem[mem_addr] : 16'hDEAD;
    always @(posedge clk) begin
        if (mem_we && int'(mem_addr) < NP) mem[mem_addr] <= mem_din;
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [NP];
    logic [DW-1:0] exp_q [$];
    bit            m_filling;
    int            m_pixel;
    logic [DW-1:0] m_color;
    int            m_losses;
    bit            m_done;
    bit            m_rv;
    bit            m_err;
    bit            g_disp;
    bit            g_draw;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_filling = 0;
        m_done    = 0;
        m_losses  = 0;
        m_rv      = 0;
        m_err     = 0;
        g_disp    = 0;
        g_draw    = 0;
    endtask

    function automatic bit in_range(input logic [AW-1:0] a);
        return int'(a) < NP;
    endfunction

    // Called at a negedge with inputs already applied; returns at next negedge.
    task automatic tick();
        bit            pend;
        bit            wturn;
        bit            dturn;
        bit            ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        #1;
        pend  = m_filling || draw_req;
        wturn = pend && (!disp_req || m_losses >= SM);
        dturn = disp_req && !wturn;
        ea = '0;
        ed = '0;
        ewe = 0;
        if (dturn) begin
            ea = disp_addr;
        end else if (wturn && m_filling) begin
            ea = AW'(m_pixel);
            ed = m_color;
            ewe = 1;
        end else if (wturn) begin
            ea = draw_addr;
            ed = draw_data;
`ifdef FB_BOUNDS_CHECK_EN
            ewe = in_range(draw_addr);
`else
            ewe = 1;
`endif
        end
        check("disp_gnt", 32'(disp_gnt), 32'(dturn));
        check("draw_gnt", 32'(draw_gnt), 32'(wturn && !m_filling));
        check("mem_we", 32'(mem_we), 32'(ewe));
        check("mem_addr", 32'(mem_addr), 32'(ea));
        check("mem_din", 32'(mem_din), 32'(ed));
        check("fill_busy", 32'(fill_busy), 32'(m_filling));
        check("fill_done", 32'(fill_done), 32'(m_done));
        check("disp_rvalid", 32'(disp_rvalid), 32'(m_rv));
        check("err_oob", 32'(err_oob), 32'(m_err));
        if (dturn) begin
            exp_q.push_back(in_range(disp_addr) ? ref_mem[disp_addr] : '0);
        end
        g_disp = dturn;
        g_draw = wturn && !m_filling;
        @(posedge clk);
        m_done = 0;
        m_rv = dturn;
`ifdef FB_BOUNDS_CHECK_EN
        if ((dturn && !in_range(disp_addr)) ||
            (wturn && !m_filling && !in_range(draw_addr))) m_err = 1;
`endif
        if (wturn && ewe) ref_mem[ea] = ed;
        if (pend && dturn) m_losses++;
        else m_losses = 0;
        if (m_filling) begin
            if (wturn) begin
                m_pixel++;
                if (m_pixel == NP) begin
                    m_filling = 0;
                    m_done = 1;
                    m_losses = 0;
                end
            end
        end else if (fill_start) begin
            m_filling = 1;
            m_pixel = 0;
            m_color = fill_color;
            m_losses = 0;
        end
        @(negedge clk);
    endtask

    task automatic reset_tick();
        #1;
        check("rst_disp_gnt", 32'(disp_gnt), 32'd0);
        check("rst_draw_gnt", 32'(draw_gnt), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_din", 32'(mem_din), 32'd0);
        @(posedge clk);
        model_reset();
        @(negedge clk);
        check("rst_fill_busy", 32'(fill_busy), 32'd0);
        check("rst_fill_done", 32'(fill_done), 32'd0);
        check("rst_rvalid", 32'(disp_rvalid), 32'd0);
        check("rst_err_oob", 32'(err_oob), 32'd0);
    endtask

    task automatic rnd_inputs(input int pdisp, input int pdraw);
        if (!disp_req || g_disp) begin
            disp_req  = ($urandom_range(99) < pdisp);
            disp_addr = AW'($urandom_range(NP - 1));
        end
        if (!draw_req || g_draw) begin
            draw_req  = ($urandom_range(99) < pdraw);
            draw_addr = AW'($urandom_range(NP - 1));
            draw_data = DW'($urandom);
        end
    endtask

    task automatic read_px(input int a);
        disp_req  = 1;
        disp_addr = AW'(a);
        tick();
        disp_req  = 0;
    endtask

    // Scoreboard monitor: every valid read beat must match the oldest
    // expected value queued by the stimulus side.
    always @(negedge clk) begin
        if (disp_rvalid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL disp_rdata: unexpected rvalid, got %0h",
                         disp_rdata);
            end else begin
                check("disp_rdata", 32'(disp_rdata), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] keep1000;
        int            n;
        bit            seen;

        for (int i = 0; i < NP; i++) begin
            mem[i]     = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[5]     = 16'h1234;
        ref_mem[5] = 16'h1234;

        model_reset();
        rst_n      = 0;
        disp_req   = 1;
        draw_req   = 1;
        disp_addr  = AW'(3);
        draw_addr  = AW'(4);
        draw_data  = 16'hAAAA;
        fill_start = 0;
        fill_color = '0;
        @(negedge clk);
        repeat (3) reset_tick();
        rst_n    = 1;
        disp_req = 0;
        draw_req = 0;
        tick();

        // Single display read of the preloaded pixel.
        read_px(5);
        tick();

        // Draw write with display idle, then read it back.
        draw_req  = 1;
        draw_addr = AW'(100);
        draw_data = 16'hF800;
        tick();
        draw_req = 0;
        read_px(100);
        tick();

        // Both held: four display grants, then one draw, repeating.
        disp_req  = 1;
        draw_req  = 1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check("starve_pattern", 32'(g_draw), 32'(i % 5 == 4));
            if (g_draw) begin
                draw_addr = AW'($urandom_range(NP - 1));
                draw_data = DW'($urandom);
            end
            if (g_disp) disp_addr = AW'($urandom_range(NP - 1));
        end
        disp_req = 0;
        draw_req = 0;
        tick();

        // Random traffic.
        repeat (400) begin
            rnd_inputs(60, 50);
            tick();
        end
        disp_req = 0;
        draw_req = 0;
        tick();

        // Fill under continuous display load, aborted by reset at pixel 1000.
        keep1000   = ref_mem[1000];
        fill_color = 16'h001F;
        fill_start = 1;
        tick();
        fill_start = 0;
        disp_req   = 1;
        n = 0;
        while (m_pixel < 1000 && n < 6000) begin
            if (n == 50) begin
                fill_start = 1;
                fill_color = 16'h0BAD;
            end
            tick();
            fill_start = 0;
            if (g_disp) disp_addr = AW'($urandom_range(NP - 1));
            n++;
        end
        check("fill_1000_reached", 32'(m_pixel), 32'd1000);
        rst_n    = 0;
        disp_req = 0;
        reset_tick();
        rst_n = 1;
        repeat (5) tick();
        check("abort_px999", 32'(mem[999]), 32'h001F);
        check("abort_px1000", 32'(mem[1000]), 32'(keep1000));
        read_px(999);
        read_px(1000);
        tick();

        // Full fill with display idle; a draw in the start cycle completes,
        // a later draw stalls until the fill is over.
        fill_color = 16'h001F;
        fill_start = 1;
        draw_req   = 1;
        draw_addr  = AW'(200);
        draw_data  = 16'hABCD;
        tick();
        fill_start = 0;
        draw_addr  = AW'(7);
        draw_data  = 16'h7777;
        n = 0;
        seen = 0;
        while (!seen && n < NP + 10) begin
            tick();
            n++;
            seen = fill_done;
        end
        check("fill_len", 32'(n), 32'(NP));
        tick();
        draw_req = 0;
        tick();
        check("fill_px0", 32'(mem[0]), 32'h001F);
        check("fill_pxlast", 32'(mem[NP-1]), 32'h001F);
        check("draw_after_fill", 32'(mem[7]), 32'h7777);
        read_px(0);
        read_px(NP - 1);
        tick();

`ifdef FB_BOUNDS_CHECK_EN
        draw_req  = 1;
        draw_addr = AW'(NP);
        draw_data = 16'h5555;
        tick();
        draw_req = 0;
        read_px(NP + 3);
        tick();
        check("oob_sticky", 32'(err_oob), 32'd1);
`endif

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares the single-port 128x160x16 pixel memory between three requesters: display scan-out reads, drawing-engine writes, and a built-in fill (clear-to-colour) engine.
- Issues exactly one memory access per cycle.
- Display has priority, with a starvation counter that guarantees writers forward progress.
- Sits between the pixel memory and the display and draw logic. Drives the memory's clk-synchronous write and its combinational read path.

Parameters:
ADDR_W, 15, pixel address width
DATA_W, 16, pixel width (RGB565)
NUM_PIXELS, 20480, framebuffer depth (128*160)
STARVE_MAX, 4, max consecutive cycles a pending writer may lose to display

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
disp_req  in  1  display read request, held until granted
disp_addr  in  ADDR_W  display read address
disp_gnt  out  1  display read granted this cycle
disp_rvalid  out  1  read data valid (cycle after grant)
disp_rdata  out  DATA_W  registered read data
draw_req  in  1  draw write request, held until granted
draw_addr  in  ADDR_W  draw write address
draw_data  in  DATA_W  draw write data
draw_gnt  out  1  draw write performed this cycle
fill_start  in  1  single-cycle pulse, begin fill
fill_color  in  DATA_W  fill colour, sampled with fill_start
fill_busy  out  1  fill in progress
fill_done  out  1  single-cycle pulse after last fill write
err_oob  out  1  sticky out-of-range flag (see Optional Feature)
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_din  out  DATA_W  memory write data
mem_dout  in  DATA_W  memory combinational read data

Behaviour:
- Reset, sampled at clk rising edge when rst_n=0:
  - State goes to IDLE; fill counter, starve_cnt, disp_rvalid, disp_rdata, fill_busy, fill_done and err_oob all clear to 0.
  - While rst_n=0, disp_gnt, draw_gnt and mem_we are forced to 0, and mem_addr and mem_din are 0.
- Grants and mem_* are combinational from requests and registered state.
- No grant in a cycle: mem_we=0, mem_addr=0, mem_din=0.
- Writer identity: draw in IDLE, fill engine in FILL. The fill engine always requests while in FILL.
- Arbitration each cycle:
  - Writer wins if it requests and either disp_req=0 or starve_cnt==STARVE_MAX.
  - Otherwise display wins if disp_req=1.
  - Display always wins if the writer is idle.
- starve_cnt:
  - Increments when the writer requests and loses to display.
  - Clears on any writer grant, or when the writer is not requesting.
  - Saturates at STARVE_MAX.
- Display grant:
  - mem_addr=disp_addr, mem_we=0.
  - At the edge: disp_rdata<=mem_dout, disp_rvalid<=1.
  - A cycle without a display grant sets disp_rvalid<=0 and holds disp_rdata.
- Draw grant: mem_addr=draw_addr, mem_din=draw_data, mem_we=1; the write lands at that edge.
- FILL state:
  - draw_gnt=0 throughout; draw requests stall.
  - A fill grant writes mem_addr=fill_cnt, mem_din=latched colour, then fill_cnt++.
  - On the grant with fill_cnt==NUM_PIXELS-1: next state IDLE, fill_busy<=0, fill_done<=1 for one cycle.
- IDLE to FILL:
  - fill_start=1 latches fill_color, clears fill_cnt, sets fill_busy, and enters FILL at the next edge.
  - A draw grant in the same cycle as fill_start still completes.
  - fill_start while fill_busy=1 is ignored.
- starve_cnt clears on any IDLE/FILL transition.
- Reset mid-fill aborts immediately: no fill_done, and pixels already written remain.
- Worst-case fill time with display continuously requesting: NUM_PIXELS*(STARVE_MAX+1) cycles.

Optional Feature:
Macro FB_BOUNDS_CHECK_EN.
- Defined:
  - A draw grant with draw_addr>=NUM_PIXELS still asserts draw_gnt, but mem_we=0, and sets err_oob (sticky until reset).
  - A display grant with disp_addr>=NUM_PIXELS returns disp_rdata=0 and sets err_oob.
- Undefined: addresses pass through unchecked and err_oob is tied 0.

Test Plan:
- Reset -> hold rst_n=0 with all requests high: disp_gnt=draw_gnt=mem_we=0. After release, disp_rvalid=0, fill_busy=0, err_oob=0.
- Display read -> memory preloaded with 0x1234 at addr 5; disp_req=1, disp_addr=5: disp_gnt=1 and mem_addr=5 in the same cycle; next cycle disp_rvalid=1, disp_rdata=0x1234.
- Draw write -> draw_req=1, addr 100, data 0xF800, display idle: draw_gnt=1, mem_we=1 that cycle; a later display read of 100 returns 0xF800.
- Starvation, STARVE_MAX=4 -> disp_req and draw_req held high: grants repeat display x4 then draw x1. No 5th consecutive display grant while draw pends.
- Fill -> fill_start with colour 0x001F, display idle:
  - fill_busy=1 from the next cycle; fill_done pulses exactly 20480 cycles after FILL entry.
  - draw_gnt=0 throughout.
  - Reads of addr 0 and 20479 return 0x001F.
  - With display continuously requesting, fill_done arrives at 20480*5 cycles.
- Reset mid-fill -> rst_n low after 1000 fill writes: fill_busy=0 after the edge, no fill_done; addr 999=0x001F, addr 1000 unchanged. With FB_BOUNDS_CHECK_EN, a draw to addr 20480 gives draw_gnt=1, mem_we=0, err_oob=1.
